// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-port NoC router input buffer.
// NUM_VC virtual channels, each backed by a DEPTH-entry FIFO, plus a
// per-VC packet state machine (IDLE/RESERVED/ACTIVE/DRAIN) that drives
// the ON_OFF availability vector seen by the upstream VC allocator.
// Optional feature macro: VCBUF_OCCUPANCY_EN adds the OCC port (per-VC
// registered counts, VC0 in the LSBs).
module vc_input_buffer #(
  parameter int FLIT_W  = 16,
  parameter int NUM_VC  = 4,
  parameter int VC_ID_W = 2,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [FLIT_W-1:0]    FLIT_i,
  input  logic [NUM_VC-1:0]    VC_Reserved,
  input  logic                 rd_en,
  input  logic [VC_ID_W-1:0]   rd_vc,
  output logic [FLIT_W-1:0]    FLIT_O,
  output logic [NUM_VC-1:0]    ON_OFF,
  output logic [NUM_VC-1:0]    EPT_FL,
  output logic [NUM_VC-1:0]    FULL,
  output logic                 tail_popped,
  output logic                 overflow_err
`ifdef VCBUF_OCCUPANCY_EN
  ,
  output logic [NUM_VC*(PTR_W+1)-1:0] OCC
`endif
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RESERVED = 2'd1,
    S_ACTIVE   = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  logic [FLIT_W-1:0] mem_q [NUM_VC][DEPTH];
  logic [FLIT_W-1:0] mem_d [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]  count_q  [NUM_VC];
  logic [CNT_W-1:0]  count_d  [NUM_VC];
  state_t            state_q  [NUM_VC];
  state_t            state_d  [NUM_VC];

  logic [NUM_VC-1:0] on_off_q, on_off_d;
  logic [NUM_VC-1:0] ept_q, ept_d;
  logic [NUM_VC-1:0] full_q, full_d;
  logic              tail_popped_q, tail_popped_d;
  logic              overflow_q, overflow_d;

  logic [VC_ID_W-1:0] wr_vc;
  logic [1:0]         wr_type;
  logic [NUM_VC-1:0]  res_sel;
  logic [NUM_VC-1:0]  push;
  logic [NUM_VC-1:0]  pop;
  logic               head_valid;
  logic               do_pop;
  logic [FLIT_W-1:0]  head_flit;
  logic               head_is_tail;

  assign wr_vc        = FLIT_i[VC_ID_W-1:0];
  assign wr_type      = FLIT_i[VC_ID_W+1:VC_ID_W];
  // Isolate the lowest set bit so a multi-hot reservation claims one VC only
  assign res_sel      = VC_Reserved & (~VC_Reserved + NUM_VC'(1));
  assign head_flit    = mem_q[rd_vc][rd_ptr_q[rd_vc]];
  assign head_valid   = (count_q[rd_vc] != '0);
  assign do_pop       = rd_en && head_valid;
  assign head_is_tail = head_flit[VC_ID_W+1];

  // FIFO datapath: pushes, pops, pointers and counts per VC
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = '0;
    pop        = '0;
    overflow_d = overflow_q;
    for (int v = 0; v < NUM_VC; v++) begin
      pop[v] = do_pop && (rd_vc == VC_ID_W'(v));
      // A full FIFO still takes the flit when the same VC pops this cycle
      push[v] = valid && (wr_vc == VC_ID_W'(v)) &&
                ((count_q[v] != CNT_FULL) || pop[v]);
      if (push[v]) begin
        mem_d[v][wr_ptr_q[v]] = FLIT_i;
        wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
      end
      if (pop[v]) begin
        rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
      end
      if (push[v] && !pop[v]) begin
        count_d[v] = count_q[v] + CNT_W'(1);
      end else if (pop[v] && !push[v]) begin
        count_d[v] = count_q[v] - CNT_W'(1);
      end
      if (valid && (wr_vc == VC_ID_W'(v)) && !push[v]) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Per-VC packet FSM next-state logic
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      state_d[v] = state_q[v];
      case (state_q[v])
        S_IDLE: begin
          if (push[v] && wr_type == 2'b11)      state_d[v] = S_DRAIN;
          else if (push[v] && wr_type == 2'b01) state_d[v] = S_ACTIVE;
          else if (res_sel[v])                  state_d[v] = S_RESERVED;
        end
        S_RESERVED: begin
          if (push[v] && wr_type == 2'b11)      state_d[v] = S_DRAIN;
          else if (push[v] && wr_type == 2'b01) state_d[v] = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (push[v] && wr_type[1])            state_d[v] = S_DRAIN;
        end
        S_DRAIN: begin
          if (pop[v] && head_is_tail)
            state_d[v] = res_sel[v] ? S_RESERVED : S_IDLE;
        end
        default: state_d[v] = S_IDLE;
      endcase
    end
  end

  // Registered status outputs derived from next state and next counts
  always_comb begin
    on_off_d      = '0;
    ept_d         = '0;
    full_d        = '0;
    tail_popped_d = do_pop && head_is_tail;
    for (int v = 0; v < NUM_VC; v++) begin
      on_off_d[v] = (state_d[v] == S_IDLE);
      ept_d[v]    = (count_d[v] != '0);
      full_d[v]   = (count_d[v] == CNT_FULL);
    end
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
        state_q[v]  <= S_IDLE;
      end
      on_off_q      <= '1;
      ept_q         <= '0;
      full_q        <= '0;
      tail_popped_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      on_off_q      <= on_off_d;
      ept_q         <= ept_d;
      full_q        <= full_d;
      tail_popped_q <= tail_popped_d;
      overflow_q    <= overflow_d;
    end
  end

  // Flit storage; contents need no reset because empty FIFOs are masked
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign FLIT_O       = head_valid ? head_flit : '0;
  assign ON_OFF       = on_off_q;
  assign EPT_FL       = ept_q;
  assign FULL         = full_q;
  assign tail_popped  = tail_popped_q;
  assign overflow_err = overflow_q;

`ifdef VCBUF_OCCUPANCY_EN
  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_occ
    assign OCC[gi*CNT_W +: CNT_W] = count_q[gi];
  end
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed, table-driven bench for vc_input_buffer (default parameters).
module tb_vc_input_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] flit_i;
  logic [3:0]  vc_reserved;
  logic        rd_en;
  logic [1:0]  rd_vc;
  logic [15:0] flit_o;
  logic [3:0]  on_off, ept_fl, full;
  logic        tail_popped, overflow_err;
`ifdef VCBUF_OCCUPANCY_EN
  logic [11:0] occ;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_input_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .FLIT_i       (flit_i),
    .VC_Reserved  (vc_reserved),
    .rd_en        (rd_en),
    .rd_vc        (rd_vc),
    .FLIT_O       (flit_o),
    .ON_OFF       (on_off),
    .EPT_FL       (ept_fl),
    .FULL         (full),
    .tail_popped  (tail_popped),
    .overflow_err (overflow_err)
`ifdef VCBUF_OCCUPANCY_EN
    ,
    .OCC          (occ)
`endif
  );

  typedef struct {
    logic        v;
    logic [15:0] flit;
    logic [3:0]  res;
    logic        rd;
    logic [1:0]  rvc;
    logic [15:0] e_flit;
    logic [3:0]  e_onoff;
    logic [3:0]  e_ept;
    logic [3:0]  e_full;
    logic        e_tp;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic v, logic [15:0] flit, logic [3:0] res,
                              logic rd, logic [1:0] rvc, logic [15:0] e_flit,
                              logic [3:0] e_onoff, logic [3:0] e_ept,
                              logic [3:0] e_full, logic e_tp, logic e_ovf);
    vec_t r;
    r.v = v; r.flit = flit; r.res = res; r.rd = rd; r.rvc = rvc;
    r.e_flit = e_flit; r.e_onoff = e_onoff; r.e_ept = e_ept;
    r.e_full = e_full; r.e_tp = e_tp; r.e_ovf = e_ovf;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle #1 after the rising edge
  task automatic apply(input logic v, input logic [15:0] flit, input logic [3:0] res,
                       input logic rd, input logic [1:0] rvc);
    @(negedge clk);
    valid = v; flit_i = flit; vc_reserved = res; rd_en = rd; rd_vc = rvc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; flit_i = '0; vc_reserved = '0; rd_en = 1'b0; rd_vc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_flit, input logic [3:0] e_onoff,
                           input logic [3:0] e_ept, input logic [3:0] e_full,
                           input logic e_tp, input logic e_ovf);
    check({tag, ".FLIT_O"}, 32'(flit_o), 32'(e_flit));
    check({tag, ".ON_OFF"}, 32'(on_off), 32'(e_onoff));
    check({tag, ".EPT_FL"}, 32'(ept_fl), 32'(e_ept));
    check({tag, ".FULL"}, 32'(full), 32'(e_full));
    check({tag, ".tail_popped"}, 32'(tail_popped), 32'(e_tp));
    check({tag, ".overflow_err"}, 32'(overflow_err), 32'(e_ovf));
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; flit_i = '0; vc_reserved = '0; rd_en = 1'b0; rd_vc = '0;

    //             v  flit      res     rd rvc  e_flit    onoff    ept      full     tp ovf
    vecs[0]  = mk(0, 16'h0000, 4'b0000, 0, 0, 16'h0000, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    vecs[1]  = mk(0, 16'h0000, 4'b0100, 0, 0, 16'h0000, 4'b1011, 4'b0000, 4'b0000, 0, 0);
    vecs[2]  = mk(1, 16'hA005, 4'b0000, 0, 1, 16'hA005, 4'b1001, 4'b0010, 4'b0000, 0, 0);
    vecs[3]  = mk(1, 16'hB009, 4'b0000, 0, 1, 16'hA005, 4'b1001, 4'b0010, 4'b0000, 0, 0);
    vecs[4]  = mk(0, 16'h0000, 4'b0000, 1, 1, 16'hB009, 4'b1001, 4'b0010, 4'b0000, 0, 0);
    vecs[5]  = mk(0, 16'h0000, 4'b0000, 1, 1, 16'h0000, 4'b1011, 4'b0000, 4'b0000, 1, 0);
    vecs[6]  = mk(0, 16'h0000, 4'b0000, 0, 1, 16'h0000, 4'b1011, 4'b0000, 4'b0000, 0, 0);
    vecs[7]  = mk(1, 16'h1003, 4'b0000, 0, 3, 16'h1003, 4'b1011, 4'b1000, 4'b0000, 0, 0);
    vecs[8]  = mk(1, 16'h2003, 4'b0000, 0, 3, 16'h1003, 4'b1011, 4'b1000, 4'b0000, 0, 0);
    vecs[9]  = mk(1, 16'h3003, 4'b0000, 0, 3, 16'h1003, 4'b1011, 4'b1000, 4'b0000, 0, 0);
    vecs[10] = mk(1, 16'h4003, 4'b0000, 0, 3, 16'h1003, 4'b1011, 4'b1000, 4'b1000, 0, 0);
    vecs[11] = mk(1, 16'h5003, 4'b0000, 0, 3, 16'h1003, 4'b1011, 4'b1000, 4'b1000, 0, 1);
    vecs[12] = mk(0, 16'h0000, 4'b0000, 1, 3, 16'h2003, 4'b1011, 4'b1000, 4'b0000, 0, 1);
    vecs[13] = mk(0, 16'h0000, 4'b0000, 1, 3, 16'h3003, 4'b1011, 4'b1000, 4'b0000, 0, 1);
    vecs[14] = mk(0, 16'h0000, 4'b0000, 1, 3, 16'h4003, 4'b1011, 4'b1000, 4'b0000, 0, 1);
    vecs[15] = mk(0, 16'h0000, 4'b0000, 1, 3, 16'h0000, 4'b1011, 4'b0000, 4'b0000, 0, 1);

    do_reset();
    #1;
    check_all("reset", 16'h0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Table: reservation, head/tail packet on VC1, VC3 overflow and drain
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].v, vecs[i].flit, vecs[i].res, vecs[i].rd, vecs[i].rvc);
      $display("vec %0d: in v=%b flit=%h res=%b rd=%b rvc=%0d -> FLIT_O=%h ON_OFF=%b EPT=%b FULL=%b tp=%b ovf=%b",
               i, vecs[i].v, vecs[i].flit, vecs[i].res, vecs[i].rd, vecs[i].rvc,
               flit_o, on_off, ept_fl, full, tail_popped, overflow_err);
      check_all($sformatf("vec%0d", i), vecs[i].e_flit, vecs[i].e_onoff, vecs[i].e_ept,
                vecs[i].e_full, vecs[i].e_tp, vecs[i].e_ovf);
    end

    // Full VC0 with simultaneous write and pop: count holds, no overflow
    do_reset();
    apply(1, 16'h0010, 4'b0000, 0, 0);
    apply(1, 16'h0020, 4'b0000, 0, 0);
    apply(1, 16'h0030, 4'b0000, 0, 0);
    apply(1, 16'h0040, 4'b0000, 0, 0);
    $display("full vc0: FULL=%b FLIT_O=%h", full, flit_o);
    check("full0.FULL", 32'(full), 32'h1);
    apply(1, 16'h1230, 4'b0000, 1, 0);
    $display("write+pop full vc0: FULL=%b FLIT_O=%h ovf=%b", full, flit_o, overflow_err);
    check("wrpop.FULL", 32'(full), 32'h1);
    check("wrpop.ovf", 32'(overflow_err), 32'h0);
    check("wrpop.FLIT_O", 32'(flit_o), 32'h0020);
    apply(0, 16'h0000, 4'b0000, 1, 0);
    check("drain0.a", 32'(flit_o), 32'h0030);
    check("drain0.full", 32'(full), 32'h0);
    apply(0, 16'h0000, 4'b0000, 1, 0);
    check("drain0.b", 32'(flit_o), 32'h0040);
    apply(0, 16'h0000, 4'b0000, 1, 0);
    check("drain0.c", 32'(flit_o), 32'h1230);
    apply(0, 16'h0000, 4'b0000, 1, 0);
    $display("drain vc0 done: FLIT_O=%h EPT=%b", flit_o, ept_fl);
    check("drain0.empty", 32'(ept_fl), 32'h0);
    check("drain0.ovf", 32'(overflow_err), 32'h0);

    // Head+tail single-flit packet on VC0
    check("ht.onoff_before", 32'(on_off[0]), 32'h1);
    apply(1, 16'h000C, 4'b0000, 0, 0);
    $display("ht write: ON_OFF=%b EPT=%b FLIT_O=%h", on_off, ept_fl, flit_o);
    check("ht.onoff_mid", 32'(on_off[0]), 32'h0);
    check("ht.ept_mid", 32'(ept_fl[0]), 32'h1);
    check("ht.flit", 32'(flit_o), 32'h000C);
    apply(0, 16'h0000, 4'b0000, 1, 0);
    $display("ht pop: ON_OFF=%b EPT=%b tp=%b", on_off, ept_fl, tail_popped);
    check("ht.onoff_after", 32'(on_off[0]), 32'h1);
    check("ht.ept_after", 32'(ept_fl[0]), 32'h0);
    check("ht.tp", 32'(tail_popped), 32'h1);

    // Tail pop coinciding with a reservation of the same VC lands in RESERVED
    apply(1, 16'h000C, 4'b0000, 0, 0);
    apply(0, 16'h0000, 4'b0001, 1, 0);
    $display("tail pop + reserve vc0: ON_OFF=%b tp=%b", on_off, tail_popped);
    check("popres.onoff", 32'(on_off[0]), 32'h0);
    check("popres.tp", 32'(tail_popped), 32'h1);

    // Multi-hot reservation honours only the lowest bit, then async reset mid-packet
    do_reset();
    apply(0, 16'h0000, 4'b0110, 0, 1);
    $display("multi-hot reserve: ON_OFF=%b", on_off);
    check("multires.onoff", 32'(on_off), 32'b1101);
    apply(1, 16'h0005, 4'b0000, 0, 1);
    apply(1, 16'h0001, 4'b0000, 0, 1);
    check("midpkt.onoff", 32'(on_off), 32'b1101);
    check("midpkt.ept", 32'(ept_fl), 32'b0010);
    check("midpkt.flit", 32'(flit_o), 32'h0005);
    @(negedge clk);
    valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    $display("async reset mid-packet: FLIT_O=%h ON_OFF=%b EPT=%b FULL=%b tp=%b ovf=%b",
             flit_o, on_off, ept_fl, full, tail_popped, overflow_err);
    check_all("asyncrst", 16'h0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
